// File: rtl/main_mem_burst.sv
// main_mem_burst: word-addressed single-port burst memory, configurable width/depth/base/latency.
// Define MAIN_MEM_BOUNDS_CHECK_EN to add the err output and out-of-range suppression.
module main_mem_burst #(
   parameter int unsigned       DATA_W       = 32,
   parameter int unsigned       ADDR_W       = 32,
   parameter int unsigned       DEPTH        = 1048576,
   parameter logic [ADDR_W-1:0] BASE_ADDR    = 'h80020000,
   parameter int unsigned       READ_LATENCY = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [ADDR_W-1:0] addr,
   input  logic              wren,
   input  logic [1:0]        acc_size,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              busy
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
   ,
   output logic              err
`endif
);

   localparam int unsigned SH = $clog2(DATA_W / 8);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RD} state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic [3:0]        last;
   logic [1:0]        lat;
   logic [AW-1:0]     base_off;
   logic              ok;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] rel;
   logic [AW-1:0]     req_off;
   logic [3:0]        req_last;
   logic              req_ok;
   logic              accept;
   logic              rd_step;
   logic              rd_fire;
   logic              rd_ok;
   logic              we0;
   logic              we1;
   logic [AW-1:0]     wa0;
   logic [AW-1:0]     rd_idx;
   logic [DATA_W-1:0] rd_word;

   assign rel     = addr - BASE_ADDR;
   assign req_off = rel[SH +: AW];
   assign accept  = enable && !busy;

   // burst length minus one from the size code
   always_comb begin
      req_last = 4'd0;
      unique case (acc_size)
         2'b00: req_last = 4'd0;
         2'b01: req_last = 4'd3;
         2'b10: req_last = 4'd7;
         2'b11: req_last = 4'd15;
      endcase
   end

`ifdef MAIN_MEM_BOUNDS_CHECK_EN
   logic [ADDR_W:0] span;
   assign span   = {1'b0, rel >> SH} + (ADDR_W+1)'(req_last);
   assign req_ok = (addr >= BASE_ADDR) && (span < (ADDR_W+1)'(DEPTH));
`else
   logic unused_rel;
   assign unused_rel = ^rel;
   assign req_ok     = 1'b1;
`endif

   // continuing write beats and the first beat of a newly accepted write
   assign wa0 = base_off + AW'(cnt);
   assign we0 = !reset && enable && (state == WR) && ok;
   assign we1 = !reset && accept && wren && req_ok;

   // a read beat is registered either mid-burst or at accept when latency is 1
   assign rd_step = enable && ((state == RD) || ((state == RD_WAIT) && (lat == 2'd0)));
   assign rd_fire = rd_step || (accept && !wren && (READ_LATENCY == 1));
   assign rd_idx  = rd_step ? wa0 : req_off;
   assign rd_ok   = rd_step ? ok : req_ok;
   assign rd_word = !rd_ok ? '0 :
                    (we0 && (wa0 == rd_idx)) ? data_in : mem[rd_idx];

   // storage; old last write beat and new first beat may land on the same edge
   always_ff @(posedge clock) begin
      if (we0) mem[wa0] <= data_in;
      if (we1) mem[req_off] <= data_in;
   end

   // burst sequencing, busy and registered read data
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         last     <= 4'd0;
         lat      <= 2'd0;
         base_off <= '0;
         ok       <= 1'b0;
         busy     <= 1'b0;
         rd_valid <= 1'b0;
         data_out <= '0;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
         err      <= 1'b0;
`endif
      end else if (enable) begin
         rd_valid <= 1'b0;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
         err      <= 1'b0;
`endif
         unique case (state)
            WR: begin
               cnt  <= cnt + 4'd1;
               busy <= ({1'b0, cnt} + 5'd1) < {1'b0, last};
               if (cnt == last) state <= IDLE;
            end
            RD_WAIT: begin
               if (lat != 2'd0) lat <= lat - 2'd1;
            end
            default: begin
            end
         endcase
         if (rd_step) begin
            cnt   <= cnt + 4'd1;
            busy  <= (cnt != last);
            state <= (cnt == last) ? IDLE : RD;
         end
         if (rd_fire) begin
            data_out <= rd_word;
            rd_valid <= 1'b1;
         end
         if (accept) begin
            base_off <= req_off;
            last     <= req_last;
            ok       <= req_ok;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
            err      <= !req_ok;
`endif
            if (wren) begin
               cnt   <= 4'd1;
               state <= (req_last == 4'd0) ? IDLE : WR;
               busy  <= (req_last > 4'd1);
            end else if (READ_LATENCY == 1) begin
               cnt   <= 4'd1;
               state <= (req_last == 4'd0) ? IDLE : RD;
               busy  <= (req_last != 4'd0);
            end else begin
               cnt   <= 4'd0;
               lat   <= 2'(READ_LATENCY - 2);
               state <= RD_WAIT;
               busy  <= 1'b1;
            end
         end
      end else begin
         rd_valid <= 1'b0;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
         err      <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_main_mem_burst.sv
// tb_main_mem_burst: scoreboard bench for main_mem_burst, two latency configurations.
// Expected read beats are queued at request time and popped by a per-instance monitor.
module tb_main_mem_burst;

   localparam logic [31:0] BASE = 32'h8002_0000;
   localparam int          DP   = 16;

   int checks = 0;
   int errors = 0;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int          idx;
      logic [31:0] d;
   } beat_t;

   for (genvar G = 0; G < 2; G++) begin : g
      localparam int L = (G == 0) ? 1 : 3;

      logic        reset    = 1'b1;
      logic        enable   = 1'b0;
      logic        wren     = 1'b0;
      logic [31:0] addr     = BASE;
      logic [1:0]  acc_size = 2'd0;
      logic [31:0] data_in  = 32'h0;
      logic [31:0] data_out;
      logic        rd_valid;
      logic        busy;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
      logic        err;
`endif

      main_mem_burst #(
         .DATA_W(32), .ADDR_W(32), .DEPTH(DP),
         .BASE_ADDR(BASE), .READ_LATENCY(L)
      ) dut (
         .clock(clock), .reset(reset), .enable(enable),
         .addr(addr), .wren(wren), .acc_size(acc_size),
         .data_in(data_in), .data_out(data_out),
         .rd_valid(rd_valid), .busy(busy)
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
         , .err(err)
`endif
      );

      logic [31:0] mm [DP];
      beat_t       q [$];
      int          adv = 0;
      int          free_adv = 0;
      bit          rst_e = 1'b1;
      bit          en_e = 1'b0;
      bit          err_e = 1'b0;
      bit          w_act = 1'b0;
      int          w_a, w_n, w_off;
      bit          w_ok;
      logic [31:0] w_d [16];
      logic [31:0] nd [16];
      logic [31:0] last_d = 32'h0;
      bit          fin = 1'b0;

      task automatic check(input string nm, input logic [31:0] act,
                           input logic [31:0] exp);
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %h want %h",
                     nm, G, $time, act, exp);
         end
      endtask

      task automatic rand_nd();
         for (int i = 0; i < 16; i++) nd[i] = $urandom;
      endtask

      // drive one cycle and advance the reference model for the coming edge
      task automatic step(input bit e, input bit r, input bit wr,
                          input logic [31:0] a, input logic [1:0] sz);
         bit          bz, acc, ok;
         int          ne, n, off;
         logic [31:0] din;
         longint      span;
         bz = adv < free_adv;
         check("busy", {31'b0, busy}, {31'b0, bz});
         ne  = adv + 1;
         acc = e && !bz && !r;
         n   = 1 << ((sz == 2'd0) ? 0 : int'(sz) + 1);
         off = int'(((a - BASE) >> 2) % DP);
         span = longint'((a - BASE) >> 2) + n - 1;
         ok  = 1'b1;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
         ok  = (a >= BASE) && (span < DP);
`endif
         din = $urandom;
         if (e && w_act && (ne - w_a < w_n)) din = w_d[ne - w_a];
         if (acc && wr) begin
            if (w_act && (ne - w_a == w_n - 1)) nd[0] = din;
            else din = nd[0];
         end
         enable = e; reset = r; wren = wr;
         addr = a; acc_size = sz; data_in = din;
         rst_e = r; en_e = e; err_e = 1'b0;
         if (r) begin
            w_act = 1'b0;
            q.delete();
            free_adv = adv;
         end else if (e) begin
            adv = ne;
            if (w_act && (ne - w_a < w_n)) begin
               if (w_ok) mm[(w_off + ne - w_a) % DP] = din;
               if (ne - w_a == w_n - 1) w_act = 1'b0;
            end
            if (acc) begin
               err_e = !ok;
               if (wr) begin
                  w_act = (n > 1); w_a = ne; w_n = n;
                  w_off = off; w_ok = ok; w_d = nd;
                  if (ok) mm[off] = din;
                  free_adv = ne + n - 2;
               end else begin
                  for (int i = 0; i < n; i++)
                     q.push_back('{ne + L - 1 + i,
                                   ok ? mm[(off + i) % DP] : 32'h0});
                  free_adv = ne + L + n - 2;
               end
            end
         end
         @(negedge clock);
      endtask

      task automatic issue(input bit wr, input logic [31:0] a,
                           input logic [1:0] sz);
         int k = 0;
         while (adv < free_adv && k < 200) begin
            step(1'b1, 1'b0, wr, a, sz);
            k++;
         end
         step(1'b1, 1'b0, wr, a, sz);
      endtask

      task automatic drain();
         int k = 0;
         while (adv < free_adv && k < 200) begin
            step(1'b1, 1'b0, 1'b0, BASE, 2'd0);
            k++;
         end
         repeat (2) step(1'b0, 1'b0, 1'b0, BASE, 2'd0);
      endtask

      // monitor: pop expected beats whenever one is due, else expect a held output
      initial begin
         forever begin
            @(posedge clock);
            #1;
            if (rst_e) begin
               check("rd_valid_rst", {31'b0, rd_valid}, 32'd0);
               check("data_out_rst", data_out, 32'd0);
               last_d = 32'h0;
            end else if (en_e && q.size() > 0 && q[0].idx == adv) begin
               check("rd_valid", {31'b0, rd_valid}, 32'd1);
               check("data_out", data_out, q[0].d);
               last_d = q[0].d;
               void'(q.pop_front());
            end else begin
               check("rd_valid_idle", {31'b0, rd_valid}, 32'd0);
               check("data_out_hold", data_out, last_d);
            end
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
            check("err", {31'b0, err}, {31'b0, err_e});
`endif
         end
      end

      // directed scenarios followed by randomized traffic
      initial begin
         bit          e, r, wr;
         logic [31:0] a;
         logic [1:0]  sz;
         @(negedge clock);
         step(1'b0, 1'b1, 1'b0, BASE, 2'd0);
         step(1'b0, 1'b1, 1'b0, BASE, 2'd0);
         rand_nd();
         issue(1'b1, BASE, 2'd3);
         drain();
         nd[0] = 32'hDEADBEEF;
         issue(1'b1, BASE, 2'd0);
         issue(1'b0, BASE, 2'd0);
         drain();
         nd[0] = 32'h11; nd[1] = 32'h22; nd[2] = 32'h33; nd[3] = 32'h44;
         issue(1'b1, BASE + 32'd4, 2'd1);
         issue(1'b0, BASE + 32'd4, 2'd1);
         drain();
         rand_nd();
         issue(1'b0, BASE, 2'd3);
         issue(1'b1, BASE + 32'd8, 2'd2);
         issue(1'b0, BASE + 32'd8, 2'd2);
         drain();
         issue(1'b0, BASE, 2'd2);
         repeat (L + 1) step(1'b1, 1'b0, 1'b0, BASE, 2'd0);
         repeat (2) step(1'b0, 1'b0, 1'b0, BASE, 2'd0);
         drain();
         rand_nd();
         issue(1'b1, BASE, 2'd3);
         repeat (4) step(1'b1, 1'b0, 1'b1, BASE, 2'd0);
         step(1'b1, 1'b1, 1'b0, BASE, 2'd0);
         issue(1'b0, BASE, 2'd3);
         drain();
         rand_nd();
         issue(1'b1, BASE + 32'd56, 2'd1);
         issue(1'b0, BASE + 32'd56, 2'd1);
         issue(1'b0, BASE, 2'd3);
         drain();
         repeat (400) begin
            e  = ($urandom_range(0, 9) != 0);
            r  = ($urandom_range(0, 199) == 0);
            wr = $urandom_range(0, 1) == 1;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)
               a = BASE - 32'($urandom_range(1, 16));
            else
               a = BASE + 32'($urandom_range(0, 18)) * 32'd4
                        + 32'($urandom_range(0, 3));
            rand_nd();
            step(e, r, wr, a, sz);
         end
         drain();
         check("pending_beats", 32'(q.size()), 32'd0);
         fin = 1'b1;
      end
   end

   initial begin
      int k = 0;
      while (!(g[0].fin && g[1].fin) && k < 20000) begin
         @(negedge clock);
         k++;
      end
      if (!(g[0].fin && g[1].fin)) begin
         checks++;
         errors++;
         $display("FAIL timeout after %0d cycles", k);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
